// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: drives the fetch address, captures PC and instruction into the
// IF/ID register, and handles load-use stalls, flush squash windows and misaligned fetches.
// Optional build macro IF_ID_PERF_COUNTERS_EN adds stall_count and bubble_count outputs.
module if_id_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned FLUSH_SLOTS = 2,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        IFIDWrite,
   input  logic        flush,
   input  logic [31:0] instr_data,
   output logic [31:0] instr_addr,
   output logic [31:0] pc_old,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        fetch_misaligned
`ifdef IF_ID_PERF_COUNTERS_EN
   ,
   output logic [31:0] stall_count,
   output logic [31:0] bubble_count
`endif
);

   typedef enum logic {StRun, StSquash} state_t;

   // Bubbles still owed after the flush edge itself.
   localparam logic [2:0] ReloadCnt  = 3'(FLUSH_SLOTS - 1);
   localparam bit         SingleSlot = (FLUSH_SLOTS == 1);

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_if_id_pc;
   logic [31:0] r_if_id_instr;
   logic        r_if_id_valid;
   logic        r_misaligned;

   logic        w_misaligned;
   logic        w_bubble;
   logic        w_stall;

   // Fetch address is a pure pass-through of the next-PC register, forced during reset.
   assign instr_addr = reset ? RESET_PC : pc_in;
   assign pc_old     = instr_addr;

   assign w_misaligned = (pc_in[1:0] != 2'b00);
   assign w_stall      = !flush && (r_state == StRun) && !IFIDWrite;
   assign w_bubble     = flush || (r_state == StSquash) ||
                         ((r_state == StRun) && IFIDWrite && w_misaligned);

   // IF/ID register and squash state machine; priority flush > squash > stall > load.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= StRun;
         r_cnt         <= 3'd0;
         r_if_id_pc    <= RESET_PC;
         r_if_id_instr <= NOP_INSTR;
         r_if_id_valid <= 1'b0;
         r_misaligned  <= 1'b0;
      end else if (flush) begin
         r_if_id_pc    <= pc_in;
         r_if_id_instr <= NOP_INSTR;
         r_if_id_valid <= 1'b0;
         if (SingleSlot) begin
            r_state <= StRun;
            r_cnt   <= 3'd0;
         end else begin
            r_state <= StSquash;
            r_cnt   <= ReloadCnt;
         end
      end else if (r_state == StSquash) begin
         r_if_id_pc    <= pc_in;
         r_if_id_instr <= NOP_INSTR;
         r_if_id_valid <= 1'b0;
         r_cnt         <= r_cnt - 3'd1;
         if (r_cnt == 3'd1) begin
            r_state <= StRun;
         end
      end else if (!IFIDWrite) begin
         r_if_id_pc    <= r_if_id_pc;
         r_if_id_instr <= r_if_id_instr;
         r_if_id_valid <= r_if_id_valid;
      end else if (w_misaligned) begin
         r_if_id_pc    <= pc_in;
         r_if_id_instr <= NOP_INSTR;
         r_if_id_valid <= 1'b0;
         r_misaligned  <= 1'b1;
      end else begin
         r_if_id_pc    <= pc_in;
         r_if_id_instr <= instr_data;
         r_if_id_valid <= 1'b1;
      end
   end

   assign if_id_pc         = r_if_id_pc;
   assign if_id_instr      = r_if_id_instr;
   assign if_id_valid      = r_if_id_valid;
   assign fetch_misaligned = r_misaligned;

`ifdef IF_ID_PERF_COUNTERS_EN
   logic [31:0] r_stall_count;
   logic [31:0] r_bubble_count;

   // Saturating event counters for stall cycles and bubble loads.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_count  <= 32'd0;
         r_bubble_count <= 32'd0;
      end else begin
         if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
         if (w_bubble && (r_bubble_count != 32'hFFFF_FFFF)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
         end
      end
   end

   assign stall_count  = r_stall_count;
   assign bubble_count = r_bubble_count;
`else
   logic w_unused;
   assign w_unused = w_stall ^ w_bubble;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the stage.
module tb_if_id_stage;

   localparam logic [31:0] ResetPc    = 32'h0000_0000;
   localparam int unsigned FlushSlots = 2;
   localparam logic [31:0] Nop        = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_in = 32'h0;
   logic        IFIDWrite = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] instr_data = 32'h0;
   logic [31:0] instr_addr, pc_old, if_id_pc, if_id_instr;
   logic        if_id_valid, fetch_misaligned;
`ifdef IF_ID_PERF_COUNTERS_EN
   logic [31:0] stall_count, bubble_count;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural model state: remaining forced bubbles rather than an FSM.
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_instr = Nop;
   logic        m_valid = 1'b0;
   logic        m_mis = 1'b0;
   int          m_owed = 0;
   longint      m_stalls = 0;
   longint      m_bubbles = 0;

   if_id_stage #(
      .RESET_PC(ResetPc),
      .FLUSH_SLOTS(FlushSlots),
      .NOP_INSTR(Nop)
   ) dut (
      .clock(clock),
      .reset(reset),
      .pc_in(pc_in),
      .IFIDWrite(IFIDWrite),
      .flush(flush),
      .instr_data(instr_data),
      .instr_addr(instr_addr),
      .pc_old(pc_old),
      .if_id_pc(if_id_pc),
      .if_id_instr(if_id_instr),
      .if_id_valid(if_id_valid),
      .fetch_misaligned(fetch_misaligned)
`ifdef IF_ID_PERF_COUNTERS_EN
      ,
      .stall_count(stall_count),
      .bubble_count(bubble_count)
`endif
   );

   always #5 clock = ~clock;

   function automatic void model_bubble();
      m_pc      = pc_in;
      m_instr   = Nop;
      m_valid   = 1'b0;
      m_bubbles = m_bubbles + 1;
   endfunction

   // One rising edge of the reference behaviour, from the inputs held across the edge.
   function automatic void model_edge();
      if (reset) begin
         m_pc = ResetPc; m_instr = Nop; m_valid = 1'b0; m_mis = 1'b0;
         m_owed = 0; m_stalls = 0; m_bubbles = 0;
      end else if (flush) begin
         model_bubble();
         m_owed = int'(FlushSlots) - 1;
      end else if (m_owed > 0) begin
         model_bubble();
         m_owed = m_owed - 1;
      end else if (!IFIDWrite) begin
         m_stalls = m_stalls + 1;
      end else if (pc_in[1:0] != 2'b00) begin
         model_bubble();
         m_mis = 1'b1;
      end else begin
         m_pc = pc_in; m_instr = instr_data; m_valid = 1'b1;
      end
   endfunction

   // Advance one clock and the model; sample outputs 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; pc_in = 32'h40; IFIDWrite = 1'b1; flush = 1'b0; instr_data = 32'hDEAD_BEEF;
      tick(); tick();
      checks++;
      if (instr_addr !== ResetPc) begin
         errors++; $display("FAIL reset_addr: got %h want %h", instr_addr, ResetPc);
      end
      checks++;
      if (pc_old !== ResetPc) begin
         errors++; $display("FAIL reset_pc_old: got %h want %h", pc_old, ResetPc);
      end
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== Nop || if_id_pc !== ResetPc) begin
         errors++;
         $display("FAIL reset_ifid: got v=%b i=%h pc=%h want v=0 i=%h pc=%h",
                  if_id_valid, if_id_instr, if_id_pc, Nop, ResetPc);
      end
      checks++;
      if (fetch_misaligned !== 1'b0) begin
         errors++; $display("FAIL reset_mis: got %b want 0", fetch_misaligned);
      end
   endtask

   task automatic test_normal();
      reset = 1'b0; pc_in = 32'h40; instr_data = 32'h00A0_0093;
      #1;
      checks++;
      if (instr_addr !== 32'h40) begin
         errors++; $display("FAIL normal_addr: got %h want 00000040", instr_addr);
      end
      tick();
      checks++;
      if (if_id_pc !== 32'h40 || if_id_instr !== 32'h00A0_0093 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL normal_load: got pc=%h i=%h v=%b want pc=00000040 i=00a00093 v=1",
                  if_id_pc, if_id_instr, if_id_valid);
      end
   endtask

   task automatic test_stall();
      IFIDWrite = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pc_in = 32'h44 + 32'(4 * i); instr_data = $urandom;
         tick();
         checks++;
         if (if_id_pc !== 32'h40 || if_id_instr !== 32'h00A0_0093 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold%0d: got pc=%h i=%h v=%b want pc=00000040 i=00a00093 v=1",
                     i, if_id_pc, if_id_instr, if_id_valid);
         end
      end
      IFIDWrite = 1'b1; instr_data = 32'h0011_0113;
      tick();
      checks++;
      if (if_id_pc !== 32'h4C || if_id_instr !== 32'h0011_0113 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: got pc=%h i=%h v=%b want pc=0000004c i=00110113 v=1",
                  if_id_pc, if_id_instr, if_id_valid);
      end
   endtask

   task automatic test_flush();
      pc_in = 32'h50; instr_data = 32'h0020_0193; flush = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         flush = 1'b0;
         checks++;
         if (if_id_instr !== Nop || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble%0d: got i=%h v=%b want i=%h v=0",
                     i, if_id_instr, if_id_valid, Nop);
         end
      end
      tick();
      checks++;
      if (if_id_pc !== 32'h50 || if_id_instr !== 32'h0020_0193 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_resume: got pc=%h i=%h v=%b want pc=00000050 i=00200193 v=1",
                  if_id_pc, if_id_instr, if_id_valid);
      end
   endtask

   task automatic test_reflush();
      int bubbles = 0;
      pc_in = 32'h58; instr_data = 32'h0030_0213; flush = 1'b1; IFIDWrite = 1'b1;
      tick();
      if (if_id_valid === 1'b0) bubbles++;
      flush = 1'b1; IFIDWrite = 1'b0;
      tick();
      if (if_id_valid === 1'b0) bubbles++;
      flush = 1'b0; IFIDWrite = 1'b1;
      tick();
      if (if_id_valid === 1'b0 && if_id_instr === Nop) bubbles++;
      checks++;
      if (bubbles != 3) begin
         errors++; $display("FAIL reflush_bubbles: got %0d want 3", bubbles);
      end
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0030_0213) begin
         errors++; $display("FAIL reflush_resume: got v=%b i=%h want v=1 i=00300213",
                            if_id_valid, if_id_instr);
      end
   endtask

   task automatic test_misaligned();
      pc_in = 32'h62; instr_data = 32'h0040_0293;
      tick();
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== Nop || fetch_misaligned !== 1'b1) begin
         errors++; $display("FAIL mis_bubble: got v=%b i=%h m=%b want v=0 i=%h m=1",
                            if_id_valid, if_id_instr, fetch_misaligned, Nop);
      end
      pc_in = 32'h64;
      tick(); tick();
      checks++;
      if (if_id_valid !== 1'b1 || fetch_misaligned !== 1'b1) begin
         errors++; $display("FAIL mis_sticky: got v=%b m=%b want v=1 m=1",
                            if_id_valid, fetch_misaligned);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (fetch_misaligned !== 1'b0) begin
         errors++; $display("FAIL mis_clear: got %b want 0", fetch_misaligned);
      end
   endtask

   task automatic test_reset_mid_squash();
      pc_in = 32'h80; instr_data = 32'h0050_0313; flush = 1'b1;
      tick();
      flush = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h80) begin
         errors++; $display("FAIL rst_squash_run: got v=%b pc=%h want v=1 pc=00000080",
                            if_id_valid, if_id_pc);
      end
`ifdef IF_ID_PERF_COUNTERS_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (stall_count !== 32'd0 || bubble_count !== 32'd0) begin
         errors++; $display("FAIL perf_reset: got s=%0d b=%0d want 0 0",
                            stall_count, bubble_count);
      end
      IFIDWrite = 1'b0;
      tick();
      IFIDWrite = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      checks++;
      if (stall_count !== 32'd1 || bubble_count !== 32'd2) begin
         errors++; $display("FAIL perf_counts: got s=%0d b=%0d want 1 2",
                            stall_count, bubble_count);
      end
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset      = ($urandom_range(0, 49) == 0);
         flush      = ($urandom_range(0, 7) == 0);
         IFIDWrite  = ($urandom_range(0, 3) != 0);
         pc_in      = {$urandom_range(0, 32'hFFFF), 14'h0, 2'b00};
         if ($urandom_range(0, 9) == 0) pc_in[1:0] = 2'($urandom_range(1, 3));
         instr_data = $urandom;
         #1;
         checks++;
         if (instr_addr !== (reset ? ResetPc : pc_in) || pc_old !== instr_addr) begin
            errors++; $display("FAIL rand_addr%0d: got %h/%h want %h", n, instr_addr, pc_old,
                               reset ? ResetPc : pc_in);
         end
         tick();
         checks++;
         if (if_id_pc !== m_pc || if_id_instr !== m_instr || if_id_valid !== m_valid ||
             fetch_misaligned !== m_mis) begin
            errors++;
            $display("FAIL rand_ifid%0d: got pc=%h i=%h v=%b m=%b want pc=%h i=%h v=%b m=%b",
                     n, if_id_pc, if_id_instr, if_id_valid, fetch_misaligned,
                     m_pc, m_instr, m_valid, m_mis);
         end
`ifdef IF_ID_PERF_COUNTERS_EN
         checks++;
         if (stall_count !== 32'(m_stalls) || bubble_count !== 32'(m_bubbles)) begin
            errors++; $display("FAIL rand_perf%0d: got s=%0d b=%0d want s=%0d b=%0d",
                               n, stall_count, bubble_count, m_stalls, m_bubbles);
         end
`endif
      end
      reset = 1'b0; flush = 1'b0; IFIDWrite = 1'b1;
   endtask

   initial begin
      test_reset();
      test_normal();
      test_stall();
      test_flush();
      test_reflush();
      test_misaligned();
      test_reset_mid_squash();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
